// File: rtl/udiv_pkg.sv
// rtl/udiv_pkg.sv - shared types and constants for the sequential unsigned divider
package udiv_pkg;

    localparam int UDIV_N = 4;
    localparam int CNT_W  = $clog2(UDIV_N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } udiv_state_e;

endpackage

// File: rtl/udiv_ge_sub.sv
// rtl/udiv_ge_sub.sv - W-bit subtract-with-borrow, carry-out is the A >= B flag
//   a_i, b_i : operands
//   diff_o   : a_i - b_i (modulo 2^W)
//   ge_o     : carry-out of a_i + ~b_i + 1, high when a_i >= b_i
module udiv_ge_sub #(
    parameter int W = 5
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         ge_o
);

    logic [W:0] sum;

    assign sum    = {1'b0, a_i} + {1'b0, ~b_i} + {{W{1'b0}}, 1'b1};
    assign diff_o = sum[W-1:0];
    assign ge_o   = sum[W];

endmodule

// File: rtl/udiv_seq.sv
// rtl/udiv_seq.sv - sequential unsigned restoring divider, one quotient bit per clock
//   CLK, RESETN      : clock, asynchronous active-low reset
//   START, I0, I1    : request with dividend and divisor, accepted when BUSY=0
//   BUSY             : division in progress
//   DONE, Q, R, DIVZ : one-cycle done pulse with quotient, remainder, divide-by-zero flag
//   Optional macro UDIV_EARLY_EXIT_EN: finish immediately when I0 < I1.
module udiv_seq
    import udiv_pkg::*;
#(
    parameter int N = UDIV_N
) (
    input  logic         CLK,
    input  logic         RESETN,
    input  logic         START,
    input  logic [N-1:0] I0,
    input  logic [N-1:0] I1,
    output logic         BUSY,
    output logic         DONE,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         DIVZ
);

    localparam int CW = $clog2(N + 1);

    udiv_state_e state_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  dvd_q, dvs_q, rem_q, quo_q;
    logic [N-1:0]  q_q, r_q;
    logic          busy_q, done_q, divz_q;

    logic [N:0]    sub_a, sub_b, sub_diff;
    logic          sub_ge;
    logic [N:0]    part;
    logic [N-1:0]  rem_d, quo_d;
    logic          unused_bits;

    // Partial remainder: previous remainder with the next dividend bit shifted in.
    assign part = {rem_q, dvd_q[N-1]};

`ifdef UDIV_EARLY_EXIT_EN
    // Outside CALC the subtractor is borrowed to compare the incoming operands.
    assign sub_a = (state_q == CALC) ? part            : {1'b0, I0};
    assign sub_b = (state_q == CALC) ? {1'b0, dvs_q}   : {1'b0, I1};
`else
    assign sub_a = part;
    assign sub_b = {1'b0, dvs_q};
`endif

    udiv_ge_sub #(.W(N + 1)) u_ge_sub (
        .a_i    (sub_a),
        .b_i    (sub_b),
        .diff_o (sub_diff),
        .ge_o   (sub_ge)
    );

    // When GE is set the difference is below the divisor, so its top bit is always zero.
    assign rem_d = sub_ge ? sub_diff[N-1:0] : part[N-1:0];
    assign quo_d = {quo_q[N-2:0], sub_ge};
    assign unused_bits = sub_diff[N] ^ quo_q[N-1];

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, FIN: begin
                    state_q <= IDLE;
                    if (START) begin
                        dvd_q <= I0;
                        dvs_q <= I1;
                        rem_q <= '0;
                        quo_q <= '0;
                        cnt_q <= '0;
                        if (I1 == '0) begin
                            q_q     <= '1;
                            r_q     <= I0;
                            divz_q  <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= FIN;
`ifdef UDIV_EARLY_EXIT_EN
                        end else if (!sub_ge) begin
                            q_q     <= '0;
                            r_q     <= I0;
                            divz_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FIN;
`endif
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    dvd_q <= {dvd_q[N-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                    // Last iteration publishes straight from the next-state values.
                    if (cnt_q == CW'(N - 1)) begin
                        q_q     <= quo_d;
                        r_q     <= rem_d;
                        divz_q  <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= FIN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign Q    = q_q;
    assign R    = r_q;
    assign DIVZ = divz_q;

endmodule

// File: tb/tb_udiv_seq.sv
// tb/tb_udiv_seq.sv - directed self-checking bench for udiv_seq (N=4)
module tb_udiv_seq;

    localparam int N = 4;
`ifdef UDIV_EARLY_EXIT_EN
    localparam int LT_LAT = 0;
`else
    localparam int LT_LAT = 4;
`endif

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] i0 = '0, i1 = '0;
    logic         busy, done, divz;
    logic [N-1:0] q, r;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    udiv_seq #(.N(N)) dut (
        .CLK    (clk),
        .RESETN (resetn),
        .START  (start),
        .I0     (i0),
        .I1     (i1),
        .BUSY   (busy),
        .DONE   (done),
        .Q      (q),
        .R      (r),
        .DIVZ   (divz)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Present a request for one edge; returns at the sample point after the acceptance edge.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        start = 1'b1;
        i0 = a;
        i1 = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count sample points until DONE, checking latency, BUSY span and result.
    task automatic wait_done(input string tag, input int exp_lat, input int eq, input int er, input int edz);
        int lat = 0;
        int bcnt = 0;
        while (!done && lat < 20) begin
            bcnt += int'(busy);
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".busy"}, bcnt, exp_lat);
        chk({tag, ".q"}, q, eq);
        chk({tag, ".r"}, r, er);
        chk({tag, ".divz"}, divz, edz);
    endtask

    initial begin
        // Reset state, with a START pulse ignored while held in reset.
        #13;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.q", q, 0);
        chk("rst.r", r, 0);
        chk("rst.divz", divz, 0);
        @(negedge clk); start = 1'b1; i0 = 4'd9; i1 = 4'd3;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("rst.start_busy", busy, 0);
        chk("rst.start_done", done, 0);
        resetn = 1'b1;

        issue(4'd13, 4'd3);
        wait_done("d13_3", 4, 4, 1, 0);
        @(negedge clk);
        chk("d13_3.pulse", done, 0);
        @(negedge clk);
        chk("d13_3.hold_q", q, 4);

        issue(4'd7, 4'd0);
        wait_done("d7_0", 0, 15, 7, 1);
        issue(4'd15, 4'd1);
        wait_done("d15_1", 4, 15, 0, 0);

        issue(4'd2, 4'd5);
        wait_done("d2_5", LT_LAT, 0, 2, 0);
        issue(4'd0, 4'd5);
        wait_done("d0_5", LT_LAT, 0, 0, 0);
        issue(4'd6, 4'd1);
        wait_done("d6_1", 4, 6, 0, 0);

        // START and operand changes while busy are ignored.
        issue(4'd9, 4'd2);
        start = 1'b1; i0 = 4'd3; i1 = 4'd1;
        @(negedge clk);
        start = 1'b0; i0 = 4'd14; i1 = 4'd7;
        wait_done("d9_2", 3, 4, 1, 0);
        // Back-to-back request in the FIN cycle.
        start = 1'b1; i0 = 4'd15; i1 = 4'd15;
        @(negedge clk);
        start = 1'b0;
        wait_done("d15_15", 4, 1, 0, 0);

        // Asynchronous reset in the middle of a calculation.
        issue(4'd12, 4'd5);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("abort.busy", busy, 0);
        chk("abort.q", q, 0);
        chk("abort.r", r, 0);
        begin
            int seen = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                seen += int'(done);
            end
            chk("abort.no_done", seen, 0);
        end
        resetn = 1'b1;
        issue(4'd12, 4'd5);
        wait_done("d12_5", 4, 2, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
